wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage of the LC-3b pipeline. It is the writer side of the register-file write port that the decode stage consumes.
- Holds the MEM/WB pipeline register and selects the writeback value (ALU result, memory word, memory byte, or PC for JSR/TRAP link).
- Drives load_regfile, wb_dest_addr and wb_dest_data into the decode-stage register file.
- Also owns the nzp condition-code register and a retired-instruction counter.

Parameters:
- DATA_W, 16, datapath width (LC-3b word). Only 16 is supported.
- REG_W, 3, register-address width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  hold the MEM/WB register contents
- flush  in  1  load a bubble into MEM/WB
- mem_valid  in  1  incoming instruction is valid
- mem_load_regfile  in  1  instruction writes a register
- mem_load_cc  in  1  instruction updates nzp
- mem_dest  in  REG_W  destination register, already resolved (R7 for JSR/TRAP)
- mem_wbsel  in  2  writeback select: 00 ALU, 01 mem word, 10 mem byte, 11 PC
- mem_alu_out  in  DATA_W  ALU/address result
- mem_rdata  in  DATA_W  memory read data
- mem_pc  in  DATA_W  incremented PC (link value)
- mem_addr_lsb  in  1  byte-select bit of the load address
- load_regfile  out  1  register-file write enable
- wb_dest_addr  out  REG_W  register-file write address
- wb_dest_data  out  DATA_W  register-file write data
- wb_valid  out  1  a valid instruction occupies WB
- cc  out  3  {n,z,p} condition codes
- retired  out  16  count of retired instructions

Behaviour:
- Reset (asynchronous, rst_n=0):
  - MEM/WB valid=0 and all captured fields = 0.
  - load_regfile=0, wb_dest_addr=0, wb_dest_data=0, wb_valid=0.
  - cc=3'b010 (Z set). retired=0.
  - Takes effect immediately, including mid-stall; the first capture happens on the first rising edge after deassertion.
- MEM/WB register, updated on the rising edge of clk. Priority: flush > stall > capture.
  - flush=1: valid<=0; other fields don't-care. Flush wins over a simultaneous stall.
  - stall=1, flush=0: all fields hold.
  - Otherwise: capture all mem_* inputs, with valid<=mem_valid.
- Writeback value, combinational from the registered fields:
  - wbsel 00: alu_out.
  - wbsel 01: rdata.
  - wbsel 10: sign-extended byte, rdata[15:8] if addr_lsb=1, else rdata[7:0].
  - wbsel 11: pc.
- Outputs:
  - wb_dest_data = writeback value; wb_dest_addr = registered dest (both driven even when invalid).
  - load_regfile = valid & registered load_regfile.
  - wb_valid = valid.
- Register-file timing: the write occurs at the clock edge that ends the cycle in which the instruction sits in WB.
  - The decode stage reads the new value in the following cycle.
  - Same-cycle bypass is not provided here.
- During a stall, load_regfile stays asserted with identical addr/data. The repeated write is idempotent and allowed.
- nzp is computed from wb_dest_data: n = bit15, z = (value==0), p = otherwise. Exactly one bit is set.
- cc register: loads nzp on the edge when valid & load_cc & !stall. Otherwise it holds. A bubble never changes cc.
- retired: increments by 1 on the edge when valid & !stall. It counts each instruction exactly once regardless of stall length.
  - Wraps 16'hFFFF -> 16'h0000 with no flag.
  - A flush in the same cycle does not suppress the count for the instruction currently leaving WB.
- Instructions with load_regfile=0 (stores, branches) still count as retired.

Test Plan:
- Reset: rst_n=0 then released, no valid input -> load_regfile=0, wb_dest_data=0, cc=3'b010, retired=0.
- ADD writeback: mem_valid=1, load_regfile=1, load_cc=1, dest=3, wbsel=00, alu_out=16'h8001 -> next cycle load_regfile=1, wb_dest_addr=3, wb_dest_data=16'h8001. The following cycle cc=3'b100 and retired=1.
- LDB sign-extension: wbsel=10, rdata=16'h7F85, addr_lsb=0 -> wb_dest_data=16'hFF85. With addr_lsb=1 -> 16'h007F, cc=3'b001 after the edge.
- JSR link: dest=7, wbsel=11, pc=16'h3002, load_cc=0 -> wb_dest_addr=7, wb_dest_data=16'h3002, cc unchanged.
- Stall then flush: valid instruction held with stall=1 for 3 cycles -> outputs constant and retired increments once, only after stall drops. Then flush=1 with stall=1 -> wb_valid=0 next cycle, load_regfile=0, cc unchanged.
- Wrap and async reset: preload retired=16'hFFFF via a stream of instructions, retire one more -> retired=16'h0000. Then assert rst_n=0 between clock edges -> outputs return to reset values before the next edge.

Source files
------------

// File: rtl/wb_stage_if.sv
// LC-3b MEM->WB bus: pipeline control, the MEM/WB capture fields and the
// register-file write port / status outputs of the writeback stage.
interface wb_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
);
  logic              stall;
  logic              flush;
  logic              mem_valid;
  logic              mem_load_regfile;
  logic              mem_load_cc;
  logic [REG_W-1:0]  mem_dest;
  logic [1:0]        mem_wbsel;
  logic [DATA_W-1:0] mem_alu_out;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] mem_pc;
  logic              mem_addr_lsb;

  logic              load_regfile;
  logic [REG_W-1:0]  wb_dest_addr;
  logic [DATA_W-1:0] wb_dest_data;
  logic              wb_valid;
  logic [2:0]        cc;
  logic [15:0]       retired;

  modport master (
    output stall, flush, mem_valid, mem_load_regfile, mem_load_cc, mem_dest,
           mem_wbsel, mem_alu_out, mem_rdata, mem_pc, mem_addr_lsb,
    input  load_regfile, wb_dest_addr, wb_dest_data, wb_valid, cc, retired
  );

  modport slave (
    input  stall, flush, mem_valid, mem_load_regfile, mem_load_cc, mem_dest,
           mem_wbsel, mem_alu_out, mem_rdata, mem_pc, mem_addr_lsb,
    output load_regfile, wb_dest_addr, wb_dest_data, wb_valid, cc, retired
  );
endinterface

// File: rtl/wb_stage.sv
// LC-3b writeback stage: MEM/WB register, writeback mux, register-file write
// port, nzp condition-code register and retired-instruction counter.
module wb_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_stage_if.slave        bus
);

  localparam logic [1:0] WBSEL_ALU  = 2'b00;
  localparam logic [1:0] WBSEL_WORD = 2'b01;
  localparam logic [1:0] WBSEL_BYTE = 2'b10;
  localparam logic [1:0] WBSEL_PC   = 2'b11;

  function automatic logic [2:0] nzp_of(input logic [DATA_W-1:0] v);
    logic [2:0] r;
    if (v[DATA_W-1]) begin
      r = 3'b100;
    end else if (v == {DATA_W{1'b0}}) begin
      r = 3'b010;
    end else begin
      r = 3'b001;
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] sext_byte(input logic [DATA_W-1:0] w,
                                                  input logic hi);
    logic [7:0] b;
    if (hi) begin
      b = w[15:8];
    end else begin
      b = w[7:0];
    end
    return {{(DATA_W-8){b[7]}}, b};
  endfunction

  logic              valid_r;
  logic              load_regfile_r;
  logic              load_cc_r;
  logic [REG_W-1:0]  dest_r;
  logic [1:0]        wbsel_r;
  logic [DATA_W-1:0] alu_out_r;
  logic [DATA_W-1:0] rdata_r;
  logic [DATA_W-1:0] pc_r;
  logic              addr_lsb_r;
  logic [2:0]        cc_r;
  logic [15:0]       retired_r;
  logic [DATA_W-1:0] wb_value_s;
  logic              leaving_s;

  // MEM/WB pipeline register: flush beats stall beats capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r        <= 1'b0;
      load_regfile_r <= 1'b0;
      load_cc_r      <= 1'b0;
      dest_r         <= {REG_W{1'b0}};
      wbsel_r        <= 2'b00;
      alu_out_r      <= {DATA_W{1'b0}};
      rdata_r        <= {DATA_W{1'b0}};
      pc_r           <= {DATA_W{1'b0}};
      addr_lsb_r     <= 1'b0;
    end else if (bus.flush) begin
      valid_r <= 1'b0;
    end else if (!bus.stall) begin
      valid_r        <= bus.mem_valid;
      load_regfile_r <= bus.mem_load_regfile;
      load_cc_r      <= bus.mem_load_cc;
      dest_r         <= bus.mem_dest;
      wbsel_r        <= bus.mem_wbsel;
      alu_out_r      <= bus.mem_alu_out;
      rdata_r        <= bus.mem_rdata;
      pc_r           <= bus.mem_pc;
      addr_lsb_r     <= bus.mem_addr_lsb;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Writeback value select
  always_comb begin
    wb_value_s = alu_out_r;
    case (wbsel_r)
      WBSEL_ALU:  wb_value_s = alu_out_r;
      WBSEL_WORD: wb_value_s = rdata_r;
      WBSEL_BYTE: wb_value_s = sext_byte(rdata_r, addr_lsb_r);
      WBSEL_PC:   wb_value_s = pc_r;
      default:    wb_value_s = alu_out_r;
    endcase
  end

  // An instruction leaves WB on an edge without stall, even if flush is set
  assign leaving_s = valid_r & ~bus.stall;

  // Condition codes and retired counter update as the instruction leaves WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_r      <= 3'b010;
      retired_r <= 16'h0000;
    end else if (leaving_s) begin
      retired_r <= retired_r + 16'h0001;
      if (load_cc_r) begin
        cc_r <= nzp_of(wb_value_s);
      end else begin
        cc_r <= cc_r;
      end
    end else begin
      cc_r      <= cc_r;
      retired_r <= retired_r;
    end
  end

  assign bus.wb_dest_data = wb_value_s;
  assign bus.wb_dest_addr = dest_r;
  assign bus.load_regfile = valid_r & load_regfile_r;
  assign bus.wb_valid     = valid_r;
  assign bus.cc           = cc_r;
  assign bus.retired      = retired_r;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table for the writeback mux/cc path,
// plus sequences for stall/flush, counter wrap and asynchronous reset.
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   passed = 0;
  int   exp_retired = 0;

  wb_stage_if #(.DATA_W(16), .REG_W(3)) bus ();

  wb_stage #(.DATA_W(16), .REG_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        ld;
    logic        ldcc;
    logic [2:0]  dest;
    logic [1:0]  wbsel;
    logic [15:0] alu;
    logic [15:0] rdata;
    logic [15:0] pc;
    logic        lsb;
    logic [15:0] exp_data;
    logic        exp_load;
    logic [2:0]  exp_cc;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic ldcc, input logic [2:0] dest,
                       input logic [1:0] wbsel, input logic [15:0] alu, input logic [15:0] rdata,
                       input logic [15:0] pc, input logic lsb);
    bus.mem_valid        = v;
    bus.mem_load_regfile = ld;
    bus.mem_load_cc      = ldcc;
    bus.mem_dest         = dest;
    bus.mem_wbsel        = wbsel;
    bus.mem_alu_out      = alu;
    bus.mem_rdata        = rdata;
    bus.mem_pc           = pc;
    bus.mem_addr_lsb     = lsb;
  endtask

  initial begin
    //          v    ld   ldcc dest  wbsel  alu       rdata     pc        lsb   data      load cc
    vecs[0] = '{1'b1,1'b1,1'b1,3'd3,2'b00,16'h8001,16'h0000,16'h0000,1'b0, 16'h8001,1'b1,3'b100};
    vecs[1] = '{1'b1,1'b1,1'b1,3'd1,2'b10,16'h0000,16'h7F85,16'h0000,1'b0, 16'hFF85,1'b1,3'b100};
    vecs[2] = '{1'b1,1'b1,1'b1,3'd2,2'b10,16'h0000,16'h7F85,16'h0000,1'b1, 16'h007F,1'b1,3'b001};
    vecs[3] = '{1'b1,1'b1,1'b0,3'd7,2'b11,16'h0000,16'h0000,16'h3002,1'b0, 16'h3002,1'b1,3'b001};
    vecs[4] = '{1'b1,1'b1,1'b1,3'd2,2'b01,16'hAAAA,16'h0000,16'h0000,1'b0, 16'h0000,1'b1,3'b010};
    vecs[5] = '{1'b1,1'b0,1'b0,3'd5,2'b00,16'h1234,16'h0000,16'h0000,1'b0, 16'h1234,1'b0,3'b010};
    vecs[6] = '{1'b0,1'b1,1'b1,3'd6,2'b00,16'hFFFF,16'h0000,16'h0000,1'b0, 16'hFFFF,1'b0,3'b010};

    rst_n     = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("rst_load", {15'd0, bus.load_regfile}, 16'h0000);
    check("rst_valid", {15'd0, bus.wb_valid}, 16'h0000);
    check("rst_data", bus.wb_dest_data, 16'h0000);
    check("rst_cc", {13'd0, bus.cc}, 16'h0002);
    check("rst_retired", bus.retired, 16'h0000);

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].valid, vecs[i].ld, vecs[i].ldcc, vecs[i].dest, vecs[i].wbsel,
            vecs[i].alu, vecs[i].rdata, vecs[i].pc, vecs[i].lsb);
      step();
      check($sformatf("v%0d_addr", i), {13'd0, bus.wb_dest_addr}, {13'd0, vecs[i].dest});
      check($sformatf("v%0d_data", i), bus.wb_dest_data, vecs[i].exp_data);
      check($sformatf("v%0d_load", i), {15'd0, bus.load_regfile}, {15'd0, vecs[i].exp_load});
      check($sformatf("v%0d_valid", i), {15'd0, bus.wb_valid}, {15'd0, vecs[i].valid});
      bus.mem_valid = 1'b0;
      step();
      if (vecs[i].valid) exp_retired++;
      check($sformatf("v%0d_cc", i), {13'd0, bus.cc}, {13'd0, vecs[i].exp_cc});
      check($sformatf("v%0d_retired", i), bus.retired, exp_retired[15:0]);
    end

    // stall holds a valid instruction for three cycles
    drive(1'b1, 1'b1, 1'b1, 3'd4, 2'b00, 16'h0042, 16'h0000, 16'h0000, 1'b0);
    step();
    drive(1'b1, 1'b1, 1'b1, 3'd6, 2'b00, 16'hDEAD, 16'h0000, 16'h0000, 1'b0);
    bus.stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("stall%0d_data", c), bus.wb_dest_data, 16'h0042);
      check($sformatf("stall%0d_addr", c), {13'd0, bus.wb_dest_addr}, 16'h0004);
      check($sformatf("stall%0d_load", c), {15'd0, bus.load_regfile}, 16'h0001);
      check($sformatf("stall%0d_retired", c), bus.retired, exp_retired[15:0]);
    end
    bus.stall = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 3'd5, 2'b00, 16'hBEEF, 16'h0000, 16'h0000, 1'b0);
    step();
    exp_retired++;
    check("unstall_retired", bus.retired, exp_retired[15:0]);
    check("unstall_cc", {13'd0, bus.cc}, 16'h0001);
    check("unstall_data", bus.wb_dest_data, 16'hBEEF);
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    step();
    check("flush_valid", {15'd0, bus.wb_valid}, 16'h0000);
    check("flush_load", {15'd0, bus.load_regfile}, 16'h0000);
    check("flush_cc", {13'd0, bus.cc}, 16'h0001);
    check("flush_retired", bus.retired, exp_retired[15:0]);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    bus.mem_valid = 1'b0;
    step();
    check("post_flush_retired", bus.retired, exp_retired[15:0]);

    // stream instructions to bring retired to 16'hFFFF, then wrap
    drive(1'b1, 1'b0, 1'b0, 3'd0, 2'b00, 16'h0001, 16'h0000, 16'h0000, 1'b0);
    for (int k = 0; k < 65535 - exp_retired; k++) begin
      step();
    end
    bus.mem_valid = 1'b0;
    step();
    check("pre_wrap", bus.retired, 16'hFFFF);
    bus.mem_valid = 1'b1;
    step();
    bus.mem_valid = 1'b0;
    step();
    check("wrap", bus.retired, 16'h0000);
    check("wrap_cc", {13'd0, bus.cc}, 16'h0001);

    // asynchronous reset between edges, while stalled on a valid writer
    drive(1'b1, 1'b1, 1'b1, 3'd3, 2'b00, 16'h5555, 16'h0000, 16'h0000, 1'b0);
    step();
    check("pre_rst_load", {15'd0, bus.load_regfile}, 16'h0001);
    bus.stall = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("arst_load", {15'd0, bus.load_regfile}, 16'h0000);
    check("arst_valid", {15'd0, bus.wb_valid}, 16'h0000);
    check("arst_addr", {13'd0, bus.wb_dest_addr}, 16'h0000);
    check("arst_data", bus.wb_dest_data, 16'h0000);
    check("arst_cc", {13'd0, bus.cc}, 16'h0002);
    check("arst_retired", bus.retired, 16'h0000);
    step();
    rst_n = 1'b1;
    bus.stall = 1'b0;
    bus.mem_valid = 1'b0;
    step();
    check("post_rst_valid", {15'd0, bus.wb_valid}, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
